flash_playback_sequencer: RTL

Parametrised flash-audio address sequencer and sample unpacker that sits between the speed-control tick generator and the flash read master. It walks a configurable address window forward or backward under keyboard commands and issues one flash word read per two sample ticks. It unpacks each 32-bit word into two 16-bit samples in direction-correct order, and supports loop or one-shot end-of-window handling. This block supersedes the fixed 23-bit forward/backward updater.

---
 rtl/flash_playback_pkg.sv | 25 ++
 rtl/tick_edge_detect.sv | 25 ++
 rtl/flash_playback_sequencer.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/flash_playback_pkg.sv
// Shared command codes, FSM states and playback direction for the flash playback sequencer.
// No logic; latency and backpressure are properties of the modules that import it.
package flash_playback_pkg;

  localparam logic [7:0] KEY_PAUSE   = 8'h44;
  localparam logic [7:0] KEY_PLAY    = 8'h45;
  localparam logic [7:0] KEY_BACK    = 8'h42;
  localparam logic [7:0] KEY_FWD     = 8'h46;
  localparam logic [7:0] KEY_RESTART = 8'h52;

  typedef enum logic [2:0] {
    PAUSED      = 3'd0,
    WAIT_TICK_A = 3'd1,
    FETCH       = 3'd2,
    WAIT_DATA   = 3'd3,
    WAIT_TICK_B = 3'd4,
    DONE        = 3'd5
  } state_t;

  typedef enum logic {
    DIR_FWD = 1'b0,
    DIR_BWD = 1'b1
  } dir_t;

endpackage

// File: rtl/tick_edge_detect.sv
// Registers the slow sample clock once and flags its rising edge as a one-cycle tick.
// Tick is high the cycle after the registered value rises; no backpressure.
module tick_edge_detect (
  input  logic clk,
  input  logic reset,
  input  logic set_clk,
  output logic tick
);

  logic set_clk_q;
  logic set_clk_qq;

  always_ff @(posedge clk) begin
    if (reset) begin
      set_clk_q  <= 1'b0;
      set_clk_qq <= 1'b0;
    end else begin
      set_clk_q  <= set_clk;
      set_clk_qq <= set_clk_q;
    end
  end

  assign tick = set_clk_q & ~set_clk_qq;

endmodule

// File: rtl/flash_playback_sequencer.sv
// Walks a flash word window under keyboard control, one read per two sample ticks, two samples per word.
// Samples appear 1 clk after readdatavalid or tick; read is held through waitrequest backpressure.
module flash_playback_sequencer
  import flash_playback_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH = 23,
  parameter logic [ADDR_WIDTH-1:0] START_ADDR = '0,
  parameter logic [ADDR_WIDTH-1:0] END_ADDR   = 23'h7FFFF,
  parameter int unsigned           DATA_WIDTH = 32,
  parameter bit                    LOOP       = 1'b1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    set_clk,
  input  logic [7:0]              keystroke,
  output logic                    read,
  output logic [ADDR_WIDTH-1:0]   addr,
  input  logic                    waitrequest,
  input  logic                    readdatavalid,
  input  logic [DATA_WIDTH-1:0]   readdata,
  output logic [DATA_WIDTH/2-1:0] sample,
  output logic                    sample_valid,
  output logic                    playing
);

  localparam int unsigned SAMPLE_WIDTH = DATA_WIDTH / 2;

  state_t                  state_q, state_n;
  dir_t                    dir_q, dir_n;
  dir_t                    word_dir_q, word_dir_n;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_n;
  logic [DATA_WIDTH-1:0]   word_q, word_n;
  logic [SAMPLE_WIDTH-1:0] sample_q, sample_n;
  logic                    sample_valid_q, sample_valid_n;
  logic                    half_pend_q, half_pend_n;
  logic                    rst_pend_q, rst_pend_n;
  logic [7:0]              key_q;
  logic                    tick;

  tick_edge_detect u_tick (
    .clk     (clk),
    .reset   (reset),
    .set_clk (set_clk),
    .tick    (tick)
  );

  logic                    key_pause, key_play, key_back, key_fwd, r_edge;
  logic                    fwd, at_edge, adv_done;
  logic [ADDR_WIDTH-1:0]   restart_addr, adv_addr;
  logic [SAMPLE_WIDTH-1:0] word_hi, word_lo, other_half;

  assign key_pause = (keystroke == KEY_PAUSE);
  assign key_play  = (keystroke == KEY_PLAY);
  assign key_back  = (keystroke == KEY_BACK);
  assign key_fwd   = (keystroke == KEY_FWD);
  // Restart fires only on the cycle the code first becomes R.
  assign r_edge    = (keystroke == KEY_RESTART) && (key_q != KEY_RESTART);

  assign fwd          = (dir_q == DIR_FWD);
  assign restart_addr = fwd ? START_ADDR : END_ADDR;
  assign at_edge      = fwd ? (addr_q == END_ADDR) : (addr_q == START_ADDR);
  assign adv_done     = at_edge && !LOOP;
  assign adv_addr     = at_edge ? restart_addr
                      : (fwd ? addr_q + ADDR_WIDTH'(1) : addr_q - ADDR_WIDTH'(1));

  assign word_hi    = word_q[DATA_WIDTH-1 -: SAMPLE_WIDTH];
  assign word_lo    = word_q[SAMPLE_WIDTH-1:0];
  assign other_half = (word_dir_q == DIR_FWD) ? word_hi : word_lo;

  always_comb begin
    state_n        = state_q;
    dir_n          = dir_q;
    word_dir_n     = word_dir_q;
    addr_n         = addr_q;
    word_n         = word_q;
    sample_n       = sample_q;
    sample_valid_n = 1'b0;
    half_pend_n    = half_pend_q;
    rst_pend_n     = rst_pend_q;

    if (key_back)     dir_n = DIR_BWD;
    else if (key_fwd) dir_n = DIR_FWD;

    case (state_q)
      PAUSED: begin
        if (r_edge) begin
          addr_n      = restart_addr;
          half_pend_n = 1'b0;
        end
        if (key_play) state_n = WAIT_TICK_A;
      end
      DONE: begin
        if (r_edge || key_play) begin
          addr_n      = restart_addr;
          half_pend_n = 1'b0;
        end
        if (key_play) state_n = WAIT_TICK_A;
      end
      WAIT_TICK_A: begin
        if (r_edge) begin
          addr_n      = restart_addr;
          half_pend_n = 1'b0;
        end
        if (key_pause) begin
          state_n = PAUSED;
        end else if (tick && !r_edge) begin
          // A half left over from a pause is emitted before the next fetch.
          if (half_pend_q) begin
            sample_n       = other_half;
            sample_valid_n = 1'b1;
            half_pend_n    = 1'b0;
            if (adv_done) state_n = DONE;
            else          addr_n  = adv_addr;
          end else begin
            state_n = FETCH;
          end
        end
      end
      FETCH: begin
        if (r_edge)       rst_pend_n = 1'b1;
        if (!waitrequest) state_n    = WAIT_DATA;
      end
      WAIT_DATA: begin
        if (r_edge) rst_pend_n = 1'b1;
        if (readdatavalid) begin
          if (rst_pend_q || r_edge) begin
            addr_n      = restart_addr;
            half_pend_n = 1'b0;
            rst_pend_n  = 1'b0;
            state_n     = WAIT_TICK_A;
          end else begin
            word_n         = readdata;
            word_dir_n     = dir_q;
            sample_n       = fwd ? readdata[SAMPLE_WIDTH-1:0]
                                 : readdata[DATA_WIDTH-1 -: SAMPLE_WIDTH];
            sample_valid_n = 1'b1;
            state_n        = WAIT_TICK_B;
          end
        end
      end
      WAIT_TICK_B: begin
        if (r_edge) begin
          addr_n      = restart_addr;
          half_pend_n = 1'b0;
          state_n     = WAIT_TICK_A;
        end else if (key_pause) begin
          half_pend_n = 1'b1;
          state_n     = PAUSED;
        end else if (tick) begin
          sample_n       = other_half;
          sample_valid_n = 1'b1;
          if (adv_done) begin
            state_n = DONE;
          end else begin
            addr_n  = adv_addr;
            state_n = WAIT_TICK_A;
          end
        end
      end
      default: state_n = PAUSED;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= PAUSED;
      dir_q          <= DIR_FWD;
      word_dir_q     <= DIR_FWD;
      addr_q         <= START_ADDR;
      word_q         <= '0;
      sample_q       <= '0;
      sample_valid_q <= 1'b0;
      half_pend_q    <= 1'b0;
      rst_pend_q     <= 1'b0;
      key_q          <= 8'h00;
    end else begin
      state_q        <= state_n;
      dir_q          <= dir_n;
      word_dir_q     <= word_dir_n;
      addr_q         <= addr_n;
      word_q         <= word_n;
      sample_q       <= sample_n;
      sample_valid_q <= sample_valid_n;
      half_pend_q    <= half_pend_n;
      rst_pend_q     <= rst_pend_n;
      key_q          <= keystroke;
    end
  end

  assign read         = (state_q == FETCH);
  assign addr         = addr_q;
  assign sample       = sample_q;
  assign sample_valid = sample_valid_q;
  assign playing      = (state_q != PAUSED) && (state_q != DONE);

endmodule
